// File: rtl/tone_burst_analyzer_if.sv
// Register-bank side bundle of the tone burst analyzer:
// tone input, configuration and measurement results.
interface tone_burst_analyzer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tone_in;
    logic                  enable;
    logic                  clear;
    logic [DATA_WIDTH-1:0] gap_threshold;
    logic [DATA_WIDTH-1:0] idle_timeout;
    logic [DATA_WIDTH-1:0] min_high;
    logic [DATA_WIDTH-1:0] meas_high;
    logic [DATA_WIDTH-1:0] meas_period;
    logic [DATA_WIDTH-1:0] meas_gap;
    logic [DATA_WIDTH-1:0] pulses_in_burst;
    logic [DATA_WIDTH-1:0] bursts_detected;
    logic                  done;
    logic [DATA_WIDTH-1:0] status_outputs;

    modport master (
        output tone_in, enable, clear,
        output gap_threshold, idle_timeout, min_high,
        input  meas_high, meas_period, meas_gap,
        input  pulses_in_burst, bursts_detected,
        input  done, status_outputs
    );

    modport slave (
        input  tone_in, enable, clear,
        input  gap_threshold, idle_timeout, min_high,
        output meas_high, meas_period, meas_gap,
        output pulses_in_burst, bursts_detected,
        output done, status_outputs
    );
endinterface

// File: rtl/tone_burst_analyzer.sv
// Tone burst analyzer: measures high time, period, pulses
// per burst, burst count and inter-burst gap of a square wave.
module tone_burst_analyzer #(
    parameter int DATA_WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    tone_burst_analyzer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_EDGE = 3'd1,
        HIGH      = 3'd2,
        LOW       = 3'd3,
        GAP       = 3'd4,
        DONE      = 3'd5
    } state_e;

    localparam logic [DATA_WIDTH-1:0] ONES = '1;
    localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);

    state_e                state_q, state_d;
    logic                  sync_q, tone_s_q, tone_d_q;
    logic [DATA_WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic [DATA_WIDTH-1:0] low_cnt_q, low_cnt_d;
    logic [DATA_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [DATA_WIDTH-1:0] meas_high_q, meas_high_d;
    logic [DATA_WIDTH-1:0] meas_period_q, meas_period_d;
    logic [DATA_WIDTH-1:0] meas_gap_q, meas_gap_d;
    logic [DATA_WIDTH-1:0] pulses_q, pulses_d;
    logic [DATA_WIDTH-1:0] bursts_q, bursts_d;
    logic                  glitch_q, glitch_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;

    logic                  rise, fall, ovf_set;
    logic [DATA_WIDTH-1:0] gth, ito;
    logic [DATA_WIDTH:0]   sum;
    logic [31:0]           stat;

    function automatic logic [DATA_WIDTH-1:0] sat_inc(
        input logic [DATA_WIDTH-1:0] v
    );
        return (v == ONES) ? v : v + ONE;
    endfunction

    assign rise = tone_s_q & ~tone_d_q;
    assign fall = ~tone_s_q & tone_d_q;
    // A zero threshold behaves as a single cycle
    assign gth  = (bus.gap_threshold == '0) ? ONE : bus.gap_threshold;
    assign ito  = (bus.idle_timeout == '0) ? ONE : bus.idle_timeout;
    assign sum  = {1'b0, high_cnt_q} + {1'b0, low_cnt_q};

    // Next-state, counter and result computation
    always_comb begin
        state_d       = state_q;
        high_cnt_d    = high_cnt_q;
        low_cnt_d     = low_cnt_q;
        pulse_cnt_d   = pulse_cnt_q;
        meas_high_d   = meas_high_q;
        meas_period_d = meas_period_q;
        meas_gap_d    = meas_gap_q;
        pulses_d      = pulses_q;
        bursts_d      = bursts_q;
        glitch_d      = glitch_q;
        done_d        = 1'b0;
        ovf_set       = 1'b0;
        if (bus.clear) begin
            state_d       = bus.enable ? WAIT_EDGE : IDLE;
            high_cnt_d    = '0;
            low_cnt_d     = '0;
            pulse_cnt_d   = '0;
            meas_high_d   = '0;
            meas_period_d = '0;
            meas_gap_d    = '0;
            pulses_d      = '0;
            bursts_d      = '0;
            glitch_d      = 1'b0;
        end else if (!bus.enable) begin
            state_d     = IDLE;
            high_cnt_d  = '0;
            low_cnt_d   = '0;
            pulse_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    high_cnt_d  = '0;
                    low_cnt_d   = '0;
                    pulse_cnt_d = '0;
                    bursts_d    = '0;
                    state_d     = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        state_d     = HIGH;
                        high_cnt_d  = ONE;
                        pulse_cnt_d = ONE;
                        low_cnt_d   = '0;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d     = LOW;
                        meas_high_d = high_cnt_q;
                        low_cnt_d   = ONE;
                        if (high_cnt_q < bus.min_high) glitch_d = 1'b1;
                    end else if (tone_s_q) begin
                        high_cnt_d = sat_inc(high_cnt_q);
                        ovf_set    = (high_cnt_q == ONES);
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_d       = HIGH;
                        meas_period_d = sum[DATA_WIDTH] ? ONES : sum[DATA_WIDTH-1:0];
                        pulse_cnt_d   = sat_inc(pulse_cnt_q);
                        high_cnt_d    = ONE;
                        ovf_set       = sum[DATA_WIDTH] | (pulse_cnt_q == ONES);
                    end else begin
                        if (!tone_s_q) begin
                            low_cnt_d = sat_inc(low_cnt_q);
                            ovf_set   = (low_cnt_q == ONES);
                        end
                        if (low_cnt_q >= gth) begin
                            state_d  = GAP;
                            pulses_d = pulse_cnt_q;
                            bursts_d = sat_inc(bursts_q);
                            ovf_set  = ovf_set | (bursts_q == ONES);
                        end
                    end
                end
                GAP: begin
                    if (rise) begin
                        state_d     = HIGH;
                        meas_gap_d  = low_cnt_q;
                        pulse_cnt_d = ONE;
                        high_cnt_d  = ONE;
                    end else begin
                        if (!tone_s_q) begin
                            low_cnt_d = sat_inc(low_cnt_q);
                            ovf_set   = (low_cnt_q == ONES);
                        end
                        if (low_cnt_q >= ito) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        overflow_d = bus.clear ? 1'b0 : (overflow_q | ovf_set);
    end

    // Input synchroniser and all state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= 1'b0;
            tone_s_q      <= 1'b0;
            tone_d_q      <= 1'b0;
            state_q       <= IDLE;
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            pulse_cnt_q   <= '0;
            meas_high_q   <= '0;
            meas_period_q <= '0;
            meas_gap_q    <= '0;
            pulses_q      <= '0;
            bursts_q      <= '0;
            glitch_q      <= 1'b0;
            overflow_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            sync_q        <= bus.tone_in;
            tone_s_q      <= sync_q;
            tone_d_q      <= tone_s_q;
            state_q       <= state_d;
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            pulse_cnt_q   <= pulse_cnt_d;
            meas_high_q   <= meas_high_d;
            meas_period_q <= meas_period_d;
            meas_gap_q    <= meas_gap_d;
            pulses_q      <= pulses_d;
            bursts_q      <= bursts_d;
            glitch_q      <= glitch_d;
            overflow_q    <= overflow_d;
            done_q        <= done_d;
        end
    end

    assign stat = {
        5'd0, state_q,
        bursts_q[7:0],
        pulse_cnt_q[7:0],
        1'b0, overflow_q, glitch_q,
        (state_q == GAP), (state_q == LOW), (state_q == HIGH),
        (state_q == DONE),
        (state_q != IDLE) && (state_q != DONE)
    };

    assign bus.status_outputs  = DATA_WIDTH'(stat);
    assign bus.meas_high       = meas_high_q;
    assign bus.meas_period     = meas_period_q;
    assign bus.meas_gap        = meas_gap_q;
    assign bus.pulses_in_burst = pulses_q;
    assign bus.bursts_detected = bursts_q;
    assign bus.done            = done_q;
endmodule

// File: tb/tb_tone_burst_analyzer.sv
// Bench for tone_burst_analyzer: pulse-train scenarios scored
// against a pulse-list model, plus clear/enable/reset cases.
module tb_tone_burst_analyzer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tone_burst_analyzer_if #(.DATA_WIDTH(32)) bus();

    tone_burst_analyzer #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] high;
        logic [31:0] period;
        logic [31:0] gap;
        logic [31:0] pulses;
        logic [31:0] bursts;
        logic [31:0] glitch;
    } exp_t;

    exp_t sbq[$];
    int   ph[$];
    int   pl[$];
    int   tests = 0;
    int   fails = 0;
    int   gap_cycles = 0;
    logic prev_done = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Expected results from the list of (high, low-after) pulse lengths:
    // a low run longer than the gap threshold ends a burst.
    function automatic exp_t model(int g, int m);
        exp_t e;
        int   g1, pcnt;
        g1 = (g == 0) ? 1 : g;
        e = '{default: '0};
        pcnt = 0;
        for (int k = 0; k < ph.size(); k++) begin
            pcnt++;
            e.high = ph[k];
            if (ph[k] < m) e.glitch = 1;
            if (k == ph.size() - 1) begin
                e.pulses = pcnt;
                e.bursts = e.bursts + 1;
            end else if (pl[k] > g1) begin
                e.pulses = pcnt;
                e.bursts = e.bursts + 1;
                e.gap = pl[k];
                pcnt = 0;
            end else begin
                e.period = ph[k] + pl[k];
            end
        end
        return e;
    endfunction

    // Monitor: score every done pulse against the queue
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_done <= 1'b0;
        end else begin
            if (prev_done) check("done_width", {31'd0, bus.done}, 32'd0);
            if (bus.done && !prev_done) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done act=1 exp=0");
                end else begin
                    e = sbq.pop_front();
                    check("meas_high", bus.meas_high, e.high);
                    check("meas_period", bus.meas_period, e.period);
                    check("meas_gap", bus.meas_gap, e.gap);
                    check("pulses_in_burst", bus.pulses_in_burst, e.pulses);
                    check("bursts_detected", bus.bursts_detected, e.bursts);
                    check("glitch_err", {31'd0, bus.status_outputs[5]}, e.glitch);
                    check("complete", {31'd0, bus.status_outputs[1]}, 32'd1);
                end
            end
            prev_done <= bus.done;
            if (bus.status_outputs[4]) gap_cycles++;
        end
    end

    task automatic drive(logic v, int n);
        bus.tone_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout pending=%0d exp=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic run_seq(int g, int i, int m);
        bus.gap_threshold = 32'(g);
        bus.idle_timeout  = 32'(i);
        bus.min_high      = 32'(m);
        bus.enable        = 1'b1;
        bus.tone_in       = 1'b0;
        pulse_clear();
        sbq.push_back(model(g, m));
        for (int k = 0; k < ph.size(); k++) begin
            drive(1'b1, ph[k]);
            drive(1'b0, pl[k]);
        end
        wait_drain(60);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_meas_high"}, bus.meas_high, 32'd0);
        check({tag, "_meas_period"}, bus.meas_period, 32'd0);
        check({tag, "_meas_gap"}, bus.meas_gap, 32'd0);
        check({tag, "_pulses"}, bus.pulses_in_burst, 32'd0);
        check({tag, "_bursts"}, bus.bursts_detected, 32'd0);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_status"}, bus.status_outputs, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, i, i1, g1, endlim, m, n;
        bus.tone_in = 1'b0;
        bus.enable = 1'b0;
        bus.clear = 1'b0;
        bus.gap_threshold = 32'd20;
        bus.idle_timeout = 32'd100;
        bus.min_high = 32'd2;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 3 high / 5 low x4, then long low
        ph = '{3, 3, 3, 3};
        pl = '{5, 5, 5, 200};
        run_seq(20, 100, 2);
        check("done_hold_state", {24'd0, bus.status_outputs[31:24]}, 32'd5);

        // two bursts separated by a 60-cycle low
        ph = '{3, 3, 3, 3, 3, 3, 3, 3};
        pl = '{5, 5, 5, 60, 5, 5, 5, 200};
        run_seq(20, 100, 2);

        // one 1-cycle glitch pulse, then clear
        ph = '{3, 1, 3, 3};
        pl = '{5, 5, 5, 200};
        run_seq(20, 100, 2);
        pulse_clear();
        check("clr_glitch", {31'd0, bus.status_outputs[5]}, 32'd0);
        check("clr_state", {24'd0, bus.status_outputs[31:24]}, 32'd1);
        check("clr_meas_high", bus.meas_high, 32'd0);
        check("clr_bursts", bus.bursts_detected, 32'd0);

        // rise exactly when the low run equals the gap threshold
        ph = '{2, 2, 2};
        pl = '{6, 6, 40};
        run_seq(6, 30, 0);

        // randomized pulse trains
        for (int s = 0; s < 15; s++) begin
            g = $urandom_range(0, 12);
            g1 = (g == 0) ? 1 : g;
            if ($urandom_range(0, 4) == 0) i = $urandom_range(0, g1);
            else i = g1 + 2 + $urandom_range(0, 20);
            i1 = (i == 0) ? 1 : i;
            endlim = (i1 > g1 + 1) ? i1 : g1 + 1;
            m = $urandom_range(0, 3);
            n = $urandom_range(1, 10);
            ph.delete();
            pl.delete();
            for (int k = 0; k < n; k++) begin
                ph.push_back($urandom_range(1, 6));
                if (k == n - 1) pl.push_back(endlim + 4);
                else if ($urandom_range(0, 3) == 0)
                    pl.push_back($urandom_range(g1 + 1, endlim));
                else pl.push_back($urandom_range(1, g1));
            end
            run_seq(g, i, m);
        end

        // enable dropped mid-HIGH
        bus.gap_threshold = 32'd20;
        bus.idle_timeout = 32'd100;
        bus.min_high = 32'd0;
        bus.enable = 1'b1;
        pulse_clear();
        drive(1'b1, 3);
        drive(1'b0, 5);
        drive(1'b1, 4);
        check("en_pre_high", {31'd0, bus.status_outputs[2]}, 32'd1);
        bus.enable = 1'b0;
        @(negedge clk);
        check("en_state", {24'd0, bus.status_outputs[31:24]}, 32'd0);
        check("en_busy", {31'd0, bus.status_outputs[0]}, 32'd0);
        check("en_meas_high", bus.meas_high, 32'd3);
        check("en_meas_period", bus.meas_period, 32'd8);
        check("en_done", {31'd0, bus.done}, 32'd0);
        drive(1'b0, 20);
        bus.enable = 1'b1;

        // asynchronous reset in the middle of LOW
        pulse_clear();
        drive(1'b1, 3);
        drive(1'b0, 4);
        check("rst_pre_low", {31'd0, bus.status_outputs[3]}, 32'd1);
        check("rst_pre_high", bus.meas_high, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // zero idle timeout: DONE on the first GAP cycle
        gap_cycles = 0;
        ph = '{2};
        pl = '{30};
        run_seq(3, 0, 0);
        check("idle0_gap_cycles", 32'(gap_cycles), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
